// File: rtl/usb_tx_pkt_pkg.sv
// usb_tx_pkt_pkg: shared USB PID constants, SYNC byte, TX FSM states and PID class helpers
package usb_tx_pkt_pkg;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_CRC_LO, S_CRC_HI} state_t;
  function automatic logic pid_is_handshake(input logic [3:0] p);
    return p == PID_ACK || p == PID_NAK || p == PID_STALL;
  endfunction
  function automatic logic pid_is_data(input logic [3:0] p);
    return p == PID_DATA0 || p == PID_DATA1;
  endfunction
endpackage

// File: rtl/usb_crc16_byte.sv
// usb_crc16_byte: combinational USB CRC16 (reflected 0xA001) update by one byte, LSB first
module usb_crc16_byte (
  input  logic [15:0] crc_in,
  input  logic [7:0]  d,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++)
      crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ d[i]) ? 16'hA001 : 16'h0000);
  end
endmodule

// File: rtl/usb_tx_pkt.sv
// usb_tx_pkt: USB handshake/data packet transmitter feeding the SIE byte interface
module usb_tx_pkt
  import usb_tx_pkt_pkg::*;
#(
  parameter int MAX_PKT = 64,
  localparam int LW = $clog2(MAX_PKT + 1)
) (
  input  logic          c,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    pid,
  input  logic [LW-1:0] len,
  input  logic [7:0]    pay_d,
  input  logic          pay_valid,
  output logic          pay_ready,
  output logic [7:0]    sie_d,
  output logic          sie_dv,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT);
  state_t        state_r;
  logic [3:0]    pid_r;
  logic [LW-1:0] cnt_r;
  logic [15:0]   crc_r;
  logic [15:0]   crc_nxt;
  logic          fin_r;
  logic          legal;
  usb_crc16_byte u_crc (.crc_in(crc_r), .d(pay_d), .crc_out(crc_nxt));
  assign legal = pid_is_handshake(pid) || (pid_is_data(pid) && len <= MAX_LEN);
  assign pay_ready = state_r == S_DATA;
  assign busy = state_r != S_IDLE;
  always_ff @(posedge c) begin
    if (rst) begin
      state_r <= S_IDLE;
      pid_r <= '0;
      cnt_r <= '0;
      crc_r <= 16'hFFFF;
      fin_r <= 1'b0;
      sie_d <= '0;
      sie_dv <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      sie_d <= '0;
      sie_dv <= 1'b0;
      fin_r <= 1'b0;
      done <= fin_r;
      err <= 1'b0;
      case (state_r)
        S_IDLE: if (start) begin
          if (legal) begin
            state_r <= S_SYNC;
            pid_r <= pid;
            cnt_r <= len;
            crc_r <= 16'hFFFF;
            sie_d <= SYNC_BYTE;
            sie_dv <= 1'b1;
          end else
            err <= 1'b1;
        end
        S_SYNC: begin
          sie_d <= {~pid_r, pid_r};
          sie_dv <= 1'b1;
          fin_r <= pid_is_handshake(pid_r);
          state_r <= pid_is_handshake(pid_r) ? S_IDLE : (cnt_r == '0 ? S_CRC_LO : S_DATA);
        end
        S_DATA: if (pay_valid) begin
          sie_d <= pay_d;
          sie_dv <= 1'b1;
          crc_r <= crc_nxt;
          cnt_r <= cnt_r - LW'(1);
          state_r <= cnt_r == LW'(1) ? S_CRC_LO : S_DATA;
        end else begin
          err <= 1'b1;
          state_r <= S_IDLE;
        end
        S_CRC_LO: begin
          sie_d <= ~crc_r[7:0];
          sie_dv <= 1'b1;
          state_r <= S_CRC_HI;
        end
        S_CRC_HI: begin
          sie_d <= ~crc_r[15:8];
          sie_dv <= 1'b1;
          fin_r <= 1'b1;
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_pkt.sv
// tb_usb_tx_pkt: directed self-checking bench for usb_tx_pkt
module tb_usb_tx_pkt;
  logic       clk = 1'b0;
  logic       rst, start, pay_valid;
  logic [3:0] pid;
  logic [6:0] len;
  logic [7:0] pay_d;
  logic       pay_ready, sie_dv, busy, done, err;
  logic [7:0] sie_d;
  logic [15:0] crc_acc;
  int total = 0;
  int passed = 0;
  usb_tx_pkt #(.MAX_PKT(64)) dut (
    .c(clk), .rst(rst), .start(start), .pid(pid), .len(len),
    .pay_d(pay_d), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .sie_d(sie_d), .sie_dv(sie_dv), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask
  task automatic chk_byte(input string tag, input logic dv, input logic [7:0] d);
    total++;
    assert ({sie_dv, sie_d} === {dv, d}) passed++;
    else $error("FAIL %s observed dv=%b d=%h expected dv=%b d=%h", tag, sie_dv, sie_d, dv, d);
  endtask
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction
  initial begin
    rst = 1'b1; start = 1'b0; pid = 4'h0; len = '0; pay_d = '0; pay_valid = 1'b0;
    tick(); tick();
    chk_byte("rst_sie", 1'b0, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_ready", pay_ready, 1'b0);
    rst = 1'b0;
    tick();
    // ACK handshake
    pid = 4'b0010; start = 1'b1;
    tick(); start = 1'b0;
    chk_byte("ack_sync", 1'b1, 8'h80);
    chk1("ack_busy", busy, 1'b1);
    tick();
    chk_byte("ack_pid", 1'b1, 8'hD2);
    chk1("ack_done_early", done, 1'b0);
    tick();
    chk_byte("ack_idle", 1'b0, 8'h00);
    chk1("ack_done", done, 1'b1);
    chk1("ack_busy_end", busy, 1'b0);
    tick();
    chk1("ack_done_pulse", done, 1'b0);
    // DATA0 zero-length packet
    pid = 4'b0011; len = 7'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk_byte("zlp_sync", 1'b1, 8'h80);
    chk1("zlp_ready0", pay_ready, 1'b0);
    tick();
    chk_byte("zlp_pid", 1'b1, 8'hC3);
    chk1("zlp_ready1", pay_ready, 1'b0);
    tick();
    chk_byte("zlp_crc_lo", 1'b1, 8'h00);
    chk1("zlp_ready2", pay_ready, 1'b0);
    tick();
    chk_byte("zlp_crc_hi", 1'b1, 8'h00);
    chk1("zlp_done_early", done, 1'b0);
    tick();
    chk_byte("zlp_end", 1'b0, 8'h00);
    chk1("zlp_done", done, 1'b1);
    tick();
    // DATA1 with 4-byte payload, a start pulse while busy, then a back-to-back ACK
    pid = 4'b1011; len = 7'd4; start = 1'b1; crc_acc = 16'hFFFF;
    tick(); start = 1'b0;
    chk_byte("d1_sync", 1'b1, 8'h80);
    chk1("d1_ready_sync", pay_ready, 1'b0);
    tick();
    chk_byte("d1_pid", 1'b1, 8'h4B);
    for (int i = 0; i < 4; i++) begin
      chk1("d1_ready", pay_ready, 1'b1);
      pay_d = 8'(i); pay_valid = 1'b1;
      start = (i == 1); pid = (i == 1) ? 4'b1001 : 4'b1011;
      crc_acc = crc_step(crc_acc, 8'(i));
      tick(); start = 1'b0;
      chk_byte("d1_payload", 1'b1, 8'(i));
      chk1("d1_no_err", err, 1'b0);
    end
    pay_valid = 1'b0;
    chk1("d1_ready_off", pay_ready, 1'b0);
    tick();
    chk_byte("d1_crc_lo", 1'b1, ~crc_acc[7:0]);
    tick();
    chk_byte("d1_crc_hi", 1'b1, ~crc_acc[15:8]);
    chk1("d1_busy_end", busy, 1'b0);
    pid = 4'b0010; start = 1'b1;
    tick(); start = 1'b0;
    chk_byte("b2b_sync", 1'b1, 8'h80);
    chk1("d1_done", done, 1'b1);
    tick();
    chk_byte("b2b_pid", 1'b1, 8'hD2);
    chk1("b2b_done_gap", done, 1'b0);
    tick();
    chk1("b2b_done", done, 1'b1);
    tick();
    // illegal requests: oversize length, unknown pid
    pid = 4'b0011; len = 7'd65; start = 1'b1;
    tick(); start = 1'b0;
    chk1("big_err", err, 1'b1);
    chk_byte("big_sie", 1'b0, 8'h00);
    chk1("big_busy", busy, 1'b0);
    tick();
    chk1("big_err_pulse", err, 1'b0);
    pid = 4'b1001; len = 7'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk1("pid_err", err, 1'b1);
    chk_byte("pid_sie", 1'b0, 8'h00);
    chk1("pid_busy", busy, 1'b0);
    tick();
    // max-length boundary accepted
    pid = 4'b0011; len = 7'd64; start = 1'b1;
    tick(); start = 1'b0;
    chk1("max_no_err", err, 1'b0);
    chk_byte("max_sync", 1'b1, 8'h80);
    rst = 1'b1;
    tick(); rst = 1'b0;
    // payload underrun on the third byte
    pid = 4'b0011; len = 7'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk_byte("ur_pid", 1'b1, 8'hC3);
    pay_d = 8'hAA; pay_valid = 1'b1;
    tick();
    chk_byte("ur_b0", 1'b1, 8'hAA);
    pay_d = 8'hBB;
    tick();
    chk_byte("ur_b1", 1'b1, 8'hBB);
    pay_valid = 1'b0;
    tick();
    chk_byte("ur_sie", 1'b0, 8'h00);
    chk1("ur_err", err, 1'b1);
    chk1("ur_busy", busy, 1'b0);
    tick();
    chk_byte("ur_no_crc", 1'b0, 8'h00);
    chk1("ur_no_done", done, 1'b0);
    chk1("ur_err_pulse", err, 1'b0);
    // reset in the middle of DATA, then a clean packet
    pid = 4'b1011; len = 7'd8; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    pay_d = 8'h55; pay_valid = 1'b1;
    tick();
    chk_byte("rm_b0", 1'b1, 8'h55);
    rst = 1'b1;
    tick(); rst = 1'b0; pay_valid = 1'b0;
    chk_byte("rm_sie", 1'b0, 8'h00);
    chk1("rm_busy", busy, 1'b0);
    chk1("rm_ready", pay_ready, 1'b0);
    tick();
    chk1("rm_no_done", done, 1'b0);
    chk1("rm_no_err", err, 1'b0);
    pid = 4'b1110; start = 1'b1;
    tick(); start = 1'b0;
    chk_byte("rm_sync", 1'b1, 8'h80);
    tick();
    chk_byte("rm_stall", 1'b1, 8'h1E);
    tick();
    chk1("rm_done", done, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
